// File: rtl/sa_weight_loader_pkg.sv
// sa_weight_loader_pkg: shared types and sizing helpers for the systolic-array weight loader
package sa_weight_loader_pkg;

   localparam int WEIGHTS_PER_WORD = 4;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DRAIN,
      DONE
   } loader_state_t;

   typedef enum logic [2:0] {
      CMD_NOP,
      CMD_WRITE_WEIGHTS,
      CMD_LOAD_INPUT,
      CMD_COMPUTE,
      CMD_READ_OUTPUT
   } command_t;

   function automatic int num_words(input int sa_size);
      return sa_size * sa_size / WEIGHTS_PER_WORD;
   endfunction

endpackage

// File: rtl/sa_weight_lifo.sv
// sa_weight_lifo: flop-array tile buffer with one write port and a combinational read port
module sa_weight_lifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;

   assign rdata = mem[raddr];

endmodule

// File: rtl/sa_weight_loader.sv
// sa_weight_loader: buffers a row-major weight tile from a valid/ready stream and
// replays it last-word-first onto the array's weight-load port
module sa_weight_loader
   import sa_weight_loader_pkg::*;
#(
   parameter int SA_SIZE    = 8,
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic                  abort,
   input  logic [WORD_WIDTH-1:0] word_in,
   input  logic                  word_valid,
   output logic                  word_ready,
   input  logic                  sa_gnt,
   output logic [WORD_WIDTH-1:0] weight_word,
   output logic                  weight_we,
   output logic                  busy,
   output logic                  done
);

   localparam int NUM_WORDS = num_words(SA_SIZE);
   localparam int PW        = $clog2(NUM_WORDS);
   localparam int CW        = $clog2(NUM_WORDS + 1);

   loader_state_t   state, nxt;
   logic [CW-1:0]   cnt;
   logic [PW-1:0]   rd_ptr;
   logic [WORD_WIDTH-1:0] rd_data;
   logic            hs;

   sa_weight_lifo #(.DEPTH(NUM_WORDS), .WIDTH(WORD_WIDTH)) u_lifo (
      .clk   (clk),
      .we    (hs),
      .waddr (cnt[PW-1:0]),
      .wdata (word_in),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   assign word_ready  = state == FILL;
   assign hs          = word_ready && word_valid;
   // abort gates the strobe in the same cycle so no stray write reaches the array
   assign weight_we   = state == DRAIN && sa_gnt && !abort;
   assign weight_word = state == DRAIN ? rd_data : '0;
   assign busy        = state != IDLE;
   assign done        = state == DONE;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = start ? FILL : IDLE;
         FILL:    nxt = hs && cnt == CW'(NUM_WORDS - 1) ? DRAIN : FILL;
         DRAIN:   nxt = weight_we && rd_ptr == '0 ? DONE : DRAIN;
         default: nxt = IDLE;
      endcase
      if (abort) nxt = IDLE;
   end

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state  <= IDLE;
         cnt    <= '0;
         rd_ptr <= '0;
      end else begin
         state  <= nxt;
         cnt    <= state == FILL && !abort ? cnt + CW'(hs) : '0;
         rd_ptr <= state == DRAIN && !abort ? rd_ptr - PW'(weight_we) :
                   nxt == DRAIN ? PW'(NUM_WORDS - 1) : '0;
      end

endmodule

// File: tb/tb_sa_weight_loader.sv
// tb_sa_weight_loader: randomized load/drain scenarios checked against a queue and array model
module tb_sa_weight_loader;

   localparam int SA  = 8;
   localparam int NW  = SA * SA / 4;
   localparam int NW4 = 4;

   logic        clk = 0, resetn = 0, start = 0, abort = 0, word_valid = 0, sa_gnt = 0;
   logic [31:0] word_in = '0;
   logic        word_ready, weight_we, busy, done;
   logic [31:0] weight_word;

   logic        s4 = 0, ab4 = 0, v4 = 0, g4 = 0;
   logic [31:0] w4 = '0;
   logic        rdy4, we4, busy4, done4;
   logic [31:0] ww4;

   sa_weight_loader #(.SA_SIZE(SA)) dut (
      .clk(clk), .resetn(resetn), .start(start), .abort(abort),
      .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
      .sa_gnt(sa_gnt), .weight_word(weight_word), .weight_we(weight_we),
      .busy(busy), .done(done)
   );

   sa_weight_loader #(.SA_SIZE(4)) dut4 (
      .clk(clk), .resetn(resetn), .start(s4), .abort(ab4),
      .word_in(w4), .word_valid(v4), .word_ready(rdy4),
      .sa_gnt(g4), .weight_word(ww4), .weight_we(we4),
      .busy(busy4), .done(done4)
   );

   always #5 clk = ~clk;

   int          n_chk = 0, n_fail = 0;
   logic [31:0] tile [NW];
   logic [31:0] tile4 [NW4];
   logic [31:0] em [$];
   logic [31:0] em4 [$];
   int          n_rdy, first_we, last_we, done_c;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic fill_fixed();
      for (int k = 0; k < NW; k++)
         tile[k] = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
   endtask

   task automatic fill_rand();
      for (int k = 0; k < NW; k++) tile[k] = $urandom;
   endtask

   // vm/gm: 0 = always high, 1 = patterned, 2 = random; ab/rs: handshake/write count that triggers abort/reset
   task automatic do_load(input int vm, input int gm, input int ab, input bit sp, input int rs);
      int n_in = 0, dc = 0;
      bit stall = 0;
      logic [31:0] pw = '0;
      em.delete();
      n_rdy = 0; first_we = -1; last_we = -1; done_c = -1;
      @(posedge clk); #1 start = 1; abort = 0; word_valid = 0; sa_gnt = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(posedge clk); #1;
         word_valid = vm == 0 ? 1'b1 : vm == 1 ? 1'(cyc % 2 == 0) : 1'($urandom_range(1, 0));
         word_in    = n_in < NW ? tile[n_in] : $urandom;
         sa_gnt     = gm == 0 ? 1'b1 : gm == 1 ? 1'(dc % 3 != 2) : 1'($urandom_range(1, 0));
         start      = sp ? 1'($urandom_range(1, 0)) : 1'b0;
         abort      = 1'(word_ready && n_in == ab);
         #1;
         if (cyc == 0) begin
            chk("ready_latency", word_ready, 1);
            chk("fill_word_zero", weight_word, 0);
         end
         if (stall) chk("stall_hold", weight_word, pw);
         if (abort) begin
            chk("abort_we", weight_we, 0);
            @(posedge clk); #1 abort = 0; start = 0; word_valid = 0; #1;
            chk("abort_busy", busy, 0);
            chk("abort_ready", word_ready, 0);
            repeat (3) begin
               @(posedge clk); #1;
               chk("abort_no_done", done, 0);
            end
            return;
         end
         if (word_ready) n_rdy++;
         if (word_ready && word_valid) n_in++;
         stall = busy && !word_ready && !done && !weight_we;
         if (busy && !word_ready && !done) dc++;
         pw = weight_word;
         if (weight_we) begin
            em.push_back(weight_word);
            if (first_we < 0) first_we = cyc;
            last_we = cyc;
         end
         if (rs >= 0 && em.size() == rs) begin
            resetn = 0; #1;
            chk("rst_we", weight_we, 0);
            chk("rst_word", weight_word, 0);
            chk("rst_ready", word_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            @(posedge clk); #1 resetn = 1; start = 0; word_valid = 0; sa_gnt = 0;
            return;
         end
         if (done) begin
            done_c = cyc;
            break;
         end
      end
      start = 0; word_valid = 0; sa_gnt = 0;
      if (done_c < 0) chk("timeout_done", 0, 1);
   endtask

   // delay-line model: the first word written ends up deepest, i.e. at tile position NW-1
   task automatic verify(input bit fixed);
      logic [7:0]  wreg [SA][SA];
      logic [31:0] w;
      logic [7:0]  e;
      int p;
      chk("we_count", em.size(), NW);
      for (int i = 0; i < em.size() && i < NW; i++) begin
         chk("order", em[i], tile[NW-1-i]);
         w = em[i];
         p = NW - 1 - i;
         for (int b = 0; b < 4; b++) wreg[p/(SA/4)][4*(p%(SA/4))+b] = w[31-8*b -: 8];
      end
      chk("done_latency", done_c, last_we + 1);
      for (int r = 0; r < SA; r++)
         for (int c = 0; c < SA; c++) begin
            w = tile[r*(SA/4)+c/4];
            e = fixed ? 8'(8*r+c) : w[31-8*(c%4) -: 8];
            chk("array", wreg[r][c], e);
         end
   endtask

   initial begin
      bit dn;
      int n4;
      #12;
      chk("reset_ready", word_ready, 0);
      chk("reset_we", weight_we, 0);
      chk("reset_word", weight_word, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      @(posedge clk); #1 resetn = 1;

      fill_fixed();
      do_load(0, 0, -1, 0, -1);
      chk("ready_cycles", n_rdy, NW);
      chk("drain_len", last_we - first_we + 1, NW);
      chk("first_word", em.size() > 0 ? em[0] : 32'hx, 32'h3C3D3E3F);
      chk("last_word", em.size() > 0 ? em[em.size()-1] : 32'hx, 32'h00010203);
      verify(1);

      do_load(1, 1, -1, 0, -1);
      verify(1);

      do_load(0, 0, 5, 0, -1);
      do_load(0, 0, -1, 0, -1);
      verify(1);

      fill_rand();
      do_load(2, 1, -1, 0, 7);
      fill_rand();
      do_load(2, 2, -1, 0, -1);
      verify(0);

      fill_fixed();
      do_load(2, 2, -1, 1, -1);
      verify(1);

      @(posedge clk); #1 start = 1; abort = 1;
      @(posedge clk); #1 start = 0; abort = 0; #1;
      chk("start_abort_busy", busy, 0);
      chk("start_abort_ready", word_ready, 0);

      repeat (3) begin
         fill_rand();
         do_load(2, 2, -1, 0, -1);
         verify(0);
      end

      for (int k = 0; k < NW4; k++)
         tile4[k] = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
      @(posedge clk); #1 s4 = 1;
      @(posedge clk); #1 s4 = 0; v4 = 1; g4 = 1;
      n4 = 0; dn = 0;
      for (int cyc = 0; cyc < 40 && !dn; cyc++) begin
         w4 = n4 < NW4 ? tile4[n4] : '0;
         #1;
         if (rdy4 && v4) n4++;
         if (we4) em4.push_back(ww4);
         if (done4) dn = 1;
         @(posedge clk); #1;
      end
      v4 = 0; g4 = 0;
      chk("sa4_done", 32'(dn), 1);
      chk("sa4_count", em4.size(), NW4);
      chk("sa4_first", em4.size() > 0 ? em4[0] : 32'hx, 32'h0C0D0E0F);
      for (int i = 0; i < em4.size() && i < NW4; i++) chk("sa4_order", em4[i], tile4[NW4-1-i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
